// File: rtl/rv32_fetch.sv
// Instruction fetch front end: owns the fetch PC, issues fixed-latency word reads,
// buffers returned instructions for decode and squashes stale work on redirect.
module rv32_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rv32_fetch_en,
  input  logic        rv32_redirect,
  input  logic [31:0] rv32_redirect_pc,
  output logic        rv32_imem_req,
  output logic [31:0] rv32_imem_addr,
  input  logic        rv32_imem_rvalid,
  input  logic [31:0] rv32_imem_rdata,
  output logic        rv32_instr_valid,
  input  logic        rv32_instr_ready,
  output logic [31:0] rv32_instr,
  output logic [31:0] rv32_instr_pc,
  output logic        rv32_fetch_err
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_pc;
  logic [31:0]     w_pc_next;
  logic            r_inflight;
  logic [31:0]     r_inflight_pc;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic            r_err;
  logic [31:0]     r_buf_instr [BUF_DEPTH];
  logic [31:0]     r_buf_pc    [BUF_DEPTH];

  logic            w_redirect;
  logic            w_misaligned;
  logic [CW-1:0]   w_occ;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;

  // A halted front end ignores redirects entirely; only reset recovers it.
  assign w_redirect   = rv32_redirect && (r_state != S_HALT);
  assign w_misaligned = (rv32_redirect_pc[1:0] != 2'b00);
  assign w_occ        = r_count + CW'(r_inflight);
  assign w_valid      = (r_count != '0);

  // Counting the outstanding read as occupied guarantees a landing slot for every response.
  assign w_issue = (r_state == S_FETCH) && rv32_fetch_en && !rv32_redirect &&
                   (w_occ < CW'(BUF_DEPTH));
  assign w_push  = rv32_imem_rvalid && r_inflight && !w_redirect;
  assign w_pop   = w_valid && rv32_instr_ready && !w_redirect;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_redirect) begin
          w_state_next = w_misaligned ? S_HALT : S_IDLE;
        end else if (rv32_fetch_en) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_redirect && w_misaligned) begin
          w_state_next = S_HALT;
        end else if (!rv32_fetch_en) begin
          w_state_next = S_IDLE;
        end
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pc_next = r_pc;
    if (w_redirect) begin
      if (!w_misaligned) begin
        w_pc_next = rv32_redirect_pc;
      end
    end else if (w_issue) begin
      w_pc_next = r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_redirect) begin
        r_inflight <= 1'b0;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        if (w_misaligned) begin
          r_err <= 1'b1;
        end
      end else begin
        if (w_issue) begin
          r_inflight    <= 1'b1;
          r_inflight_pc <= r_pc;
        end else if (rv32_imem_rvalid) begin
          r_inflight <= 1'b0;
        end
        r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        r_rd_ptr <= r_rd_ptr + PW'(w_pop);
        r_wr_ptr <= r_wr_ptr + PW'(w_push);
      end
    end
  end

  // Buffer storage carries no reset; the head is masked whenever the buffer is empty.
  generate
    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (w_push && (r_wr_ptr == PW'(gi))) begin
          r_buf_instr[gi] <= rv32_imem_rdata;
          r_buf_pc[gi]    <= r_inflight_pc;
        end
      end
    end
  endgenerate

  assign rv32_imem_req    = w_issue;
  assign rv32_imem_addr   = r_pc;
  assign rv32_instr_valid = w_valid;
  assign rv32_instr       = w_valid ? r_buf_instr[r_rd_ptr] : 32'd0;
  assign rv32_instr_pc    = w_valid ? r_buf_pc[r_rd_ptr]    : 32'd0;
  assign rv32_fetch_err   = r_err;

endmodule

// File: tb/tb_rv32_fetch.sv
// Self-checking bench for rv32_fetch: directed scenarios followed by random traffic,
// compared every cycle against a queue-based model of the fetch front end.
module tb_rv32_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch PC, run/halt flags, one outstanding read, FIFO of {instr, pc}.
  logic [31:0] m_pc;
  bit          m_run;
  bit          m_halt;
  bit          m_err;
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [63:0] m_q[$];

  // Memory model: answers whatever the DUT requested on the following cycle.
  bit          mem_pending = 1'b0;
  logic [31:0] mem_addr = 32'd0;

  always #5 clk = ~clk;

  rv32_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .rv32_fetch_en    (fetch_en),
    .rv32_redirect    (redirect),
    .rv32_redirect_pc (redirect_pc),
    .rv32_imem_req    (imem_req),
    .rv32_imem_addr   (imem_addr),
    .rv32_imem_rvalid (imem_rvalid),
    .rv32_imem_rdata  (imem_rdata),
    .rv32_instr_valid (instr_valid),
    .rv32_instr_ready (instr_ready),
    .rv32_instr       (instr),
    .rv32_instr_pc    (instr_pc),
    .rv32_fetch_err   (fetch_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_run  = 1'b0;
    m_halt = 1'b0;
    m_err  = 1'b0;
    m_infl = 1'b0;
    m_infl_pc = 32'd0;
    m_q.delete();
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check1 ("rst_req",   imem_req,    1'b0);
    check32("rst_addr",  imem_addr,   RESET_PC);
    check1 ("rst_valid", instr_valid, 1'b0);
    check32("rst_instr", instr,       32'd0);
    check32("rst_ipc",   instr_pc,    32'd0);
    check1 ("rst_err",   fetch_err,   1'b0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    // A late response after reset release must be ignored.
    mem_pending = 1'b1;
    mem_addr    = 32'h0000_0040;
    $display("reset applied");
  endtask

  task automatic cycle(input bit fe, input bit rd, input logic [31:0] rdpc,
                       input bit rdy, input bit spur);
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_ipc;
    bit          rv;
    @(negedge clk);
    fetch_en    = fe;
    redirect    = rd;
    redirect_pc = rdpc;
    instr_ready = rdy;
    rv          = mem_pending | spur;
    imem_rvalid = rv;
    imem_rdata  = mem_pending ? mem_word(mem_addr) : $urandom;
    #1;
    exp_req   = !m_halt && m_run && fe && !rd && ((m_q.size() + int'(m_infl)) < DEPTH);
    exp_valid = (m_q.size() > 0);
    exp_instr = exp_valid ? m_q[0][63:32] : 32'd0;
    exp_ipc   = exp_valid ? m_q[0][31:0]  : 32'd0;
    check1 ("req",   imem_req,    exp_req);
    check32("addr",  imem_addr,   m_pc);
    check1 ("valid", instr_valid, exp_valid);
    check32("instr", instr,       exp_instr);
    check32("ipc",   instr_pc,    exp_ipc);
    check1 ("err",   fetch_err,   m_err);
    $display("t=%0t fe=%b rd=%b rdpc=%h rdy=%b rv=%b req=%b addr=%h valid=%b ipc=%h instr=%h",
             $time, fe, rd, rdpc, rdy, rv, imem_req, imem_addr, instr_valid, instr_pc, instr);
    mem_pending = imem_req;
    mem_addr    = imem_addr;
    if (!m_halt) begin
      if (rd) begin
        m_q.delete();
        m_infl = 1'b0;
        if (rdpc[1:0] != 2'b00) begin
          m_err  = 1'b1;
          m_halt = 1'b1;
          m_run  = 1'b0;
        end else begin
          m_pc  = rdpc;
          m_run = m_run && fe;
        end
      end else begin
        if (exp_valid && rdy) void'(m_q.pop_front());
        if (rv && m_infl) m_q.push_back({mem_word(m_infl_pc), m_infl_pc});
        if (exp_req) begin
          m_infl    = 1'b1;
          m_infl_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end else if (rv) begin
          m_infl = 1'b0;
        end
        m_run = fe;
      end
    end
  endtask

  initial begin
    int k;
    bit          r_fe;
    bit          r_rd;
    bit          r_rdy;
    bit          r_spur;
    logic [31:0] r_pc;

    do_reset();

    // Streaming from reset with decode always ready.
    repeat (8) cycle(1, 0, 32'd0, 1, 0);

    // Decode stalls: buffer fills, then a single pop frees one slot.
    repeat (6) cycle(1, 0, 32'd0, 0, 0);
    cycle(1, 0, 32'd0, 1, 0);
    repeat (4) cycle(1, 0, 32'd0, 0, 0);
    repeat (3) cycle(1, 0, 32'd0, 1, 0);

    // Redirect in a cycle where a response returns.
    k = 0;
    while (!mem_pending && k < 8) begin
      cycle(1, 0, 32'd0, 1, 0);
      k++;
    end
    check1("resp_pending_before_redirect", mem_pending, 1'b1);
    cycle(1, 1, 32'h0000_0100, 1, 0);
    repeat (6) cycle(1, 0, 32'd0, 1, 0);

    // Misaligned redirect halts; later redirects are ignored until reset.
    cycle(1, 1, 32'h0000_0102, 1, 0);
    repeat (3) cycle(1, 0, 32'd0, 1, 1);
    cycle(1, 1, 32'h0000_0200, 1, 0);
    repeat (2) cycle(1, 0, 32'd0, 1, 0);
    do_reset();
    repeat (5) cycle(1, 0, 32'd0, 1, 0);

    // PC wrap-around at the top of the address space.
    cycle(1, 1, 32'hFFFF_FFF8, 1, 0);
    repeat (6) cycle(1, 0, 32'd0, 1, 0);

    // fetch_en dropped right after a request, then re-enabled.
    cycle(1, 0, 32'd0, 0, 0);
    repeat (5) cycle(0, 0, 32'd0, 1, 0);
    repeat (4) cycle(1, 0, 32'd0, 1, 0);

    // Redirect while idle loads the PC without starting fetch.
    repeat (2) cycle(0, 0, 32'd0, 1, 0);
    cycle(1, 1, 32'h0000_0300, 1, 0);
    repeat (5) cycle(1, 0, 32'd0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r_fe   = ($urandom % 8) != 0;
      r_rd   = ($urandom % 16) == 0;
      r_rdy  = ($urandom % 3) != 0;
      r_spur = ($urandom % 5) == 0;
      if (($urandom % 4) == 0) r_pc = 32'hFFFF_FFF0 + 32'(($urandom % 4) * 4);
      else                     r_pc = $urandom & 32'hFFFF_FFFC;
      if (r_rd && (($urandom % 12) == 0)) begin
        r_pc[1:0] = 2'(1 + ($urandom % 3));
        cycle(r_fe, 1, r_pc, r_rdy, r_spur);
        repeat (3) cycle(1, 0, 32'd0, 1, 0);
        do_reset();
      end else begin
        cycle(r_fe, r_rd, r_pc, r_rdy, r_spur);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
